// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Valid/ready request and response ports; sequential shift-add and restoring division.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      sel,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = XLEN / BPC;
    localparam int CW  = $clog2(N + 1);
    localparam int PW  = XLEN + BPC;

    localparam logic [CW-1:0]   LAST = CW'(N - 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [2:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   d;
    logic [2*XLEN-1:0] acc;
    logic              neg_q;
    logic              neg_r;
    logic [CW-1:0]     cnt;

    logic            signed_a;
    logic            signed_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;

    assign signed_a = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    assign signed_b = signed_a && (op != 3'd2);
    assign neg_a    = signed_a & a[XLEN-1];
    assign neg_b    = signed_b & b[XLEN-1];
    assign mag_a    = neg_a ? -a : a;
    assign mag_b    = neg_b ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == MINV) && (b == '1);

    logic [PW-1:0]     psum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     r;
    logic [XLEN-1:0]   q;
    logic [2*XLEN-1:0] div_nxt;

    // Multiplier bits are consumed from the low half while the partial
    // product shifts in from the top.
    always_comb begin
        psum = PW'(acc[2*XLEN-1:XLEN])
             + PW'(d) * PW'(acc[BPC-1:0]);
        mul_nxt = {psum, acc[XLEN-1:BPC]};
    end

    // Remainder lives in the high half, dividend/quotient in the low half.
    always_comb begin
        r = {1'b0, acc[2*XLEN-1:XLEN]};
        q = acc[XLEN-1:0];
        for (int i = 0; i < BPC; i++) begin
            r = {r[XLEN-1:0], q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        div_nxt = {r[XLEN-1:0], q};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res = prod[2*XLEN-1:XLEN];
        case (op)
            3'd0:       fix_res = prod[XLEN-1:0];
            3'd4, 3'd5: fix_res = quo;
            3'd6, 3'd7: fix_res = rem;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op    <= '0;
            a     <= '0;
            b     <= '0;
            d     <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            res   <= '0;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= sel;
                        a     <= op1;
                        b     <= op2;
                        state <= PREP;
                    end
                end
                PREP: begin
                    cnt   <= '0;
                    neg_q <= neg_a ^ neg_b;
                    neg_r <= neg_a;
                    if (div_zero) begin
                        res   <= op[1] ? a : '1;
                        state <= DONE;
                    end else if (div_ovf) begin
                        res   <= op[1] ? '0 : MINV;
                        state <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        d     <= mag_b;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= op[2] ? div_nxt : mul_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res   <= fix_res;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: BPC=1 and BPC=4 instances,
// directed RV32M cases plus random ops against an arithmetic reference.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] r;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        iv1, iv4;
    logic        ir1, ir4;
    logic [2:0]  s1, s4;
    logic [31:0] a1, a4, b1, b4;
    logic        kill1, kill4;
    logic        ov1, ov4;
    logic        or1, or4;
    logic [31:0] r1, r4;

    int   cyc;
    int   checks;
    int   errs;
    bit   seen1, seen4;
    exp_t q1[$];
    exp_t q4[$];

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .sel(s1), .op1(a1), .op2(b1), .kill(kill1),
        .out_valid(ov1), .out_ready(or1), .res(r1)
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .sel(s4), .op1(a4), .op2(b4), .kill(kill4),
        .out_valid(ov4), .out_ready(or4), .res(r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] s,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] p;
        logic        ovf;
        ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
        case (s)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
            3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input int w, input logic [2:0] s,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input bit push);
        exp_t it;
        int   n;
        bit   spec;
        n = 0;
        @(negedge clk);
        while (((w == 1) ? !ir1 : !ir4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", (w == 1) ? ir1 : ir4, 1);
        if (w == 1) begin
            iv1 = 1'b1; s1 = s; a1 = x; b1 = y;
        end else begin
            iv4 = 1'b1; s4 = s; a4 = x; b4 = y;
        end
        @(posedge clk);
        #1;
        if (w == 1) iv1 = 1'b0;
        else iv4 = 1'b0;
        spec = s[2] && ((y == 0) ||
               (!s[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
        it.r   = e;
        it.acc = cyc;
        it.lat = spec ? 1 : ((w == 1) ? 34 : 10);
        if (push) begin
            if (w == 1) q1.push_back(it);
            else q4.push_back(it);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q1.size() + q4.size(), 0);
    endtask

    // Monitor: compares every presented response against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (q1.size() == 0) begin
                    chk("spurious_valid1", ov1, 1'b0);
                end else if (ov1) begin
                    if (!seen1) begin
                        chk("latency1", cyc - q1[0].acc, q1[0].lat);
                        seen1 = 1'b1;
                    end
                    chk("res1", r1, q1[0].r);
                    chk("in_ready_busy1", ir1, 1'b0);
                    if (or1) begin
                        void'(q1.pop_front());
                        seen1 = 1'b0;
                    end
                end else begin
                    chk("in_ready_busy1", ir1, 1'b0);
                end
                if (q4.size() == 0) begin
                    chk("spurious_valid4", ov4, 1'b0);
                end else if (ov4) begin
                    if (!seen4) begin
                        chk("latency4", cyc - q4[0].acc, q4[0].lat);
                        seen4 = 1'b1;
                    end
                    chk("res4", r4, q4[0].r);
                    if (or4) begin
                        void'(q4.pop_front());
                        seen4 = 1'b0;
                    end
                end
            end
        end
    end

    logic [2:0]  dsel [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6,
                               3'd5, 3'd7, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] dx   [14] = '{32'h7, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'h7, 32'h5, 32'h5, 32'h80000000,
                               32'h80000000};
    logic [31:0] dy   [14] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h2, 32'h2, 32'h2, 32'h2,
                               32'h2, 32'hFFFFFFFE, 32'h0, 32'h0,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] dexp [14] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE,
                               32'hFFFFFFFF, 32'h0, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1,
                               32'h1, 32'hFFFFFFFF, 32'h5, 32'h80000000,
                               32'h0};

    initial begin
        logic [2:0]  s;
        logic [31:0] x, y;
        int          n;
        checks = 0;
        errs   = 0;
        seen1  = 1'b0;
        seen4  = 1'b0;
        rst_n  = 1'b1;
        iv1 = 1'b0; s1 = '0; a1 = '0; b1 = '0; kill1 = 1'b0; or1 = 1'b1;
        iv4 = 1'b0; s4 = '0; a4 = '0; b4 = '0; kill4 = 1'b0; or4 = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_in_ready", ir1, 1'b1);
        chk("reset_out_valid", ov1, 1'b0);
        chk("reset_res", r1, 32'h0);
        chk("reset_res4", r4, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(4, 3'd4, 32'd100, 32'd7, 32'd14, 1'b1);
        for (int i = 0; i < 14; i++)
            issue(1, dsel[i], dx[i], dy[i], dexp[i], 1'b1);
        drain();

        // Backpressure: hold the response for 10 cycles.
        @(posedge clk);
        #1 or1 = 1'b0;
        issue(1, 3'd3, 32'h12345678, 32'h9ABCDEF0,
              ref_model(3'd3, 32'h12345678, 32'h9ABCDEF0), 1'b1);
        n = 0;
        while (!ov1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_timeout", ov1, 1'b1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 or1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_hs", ir1, 1'b1);

        // Kill during iteration 16.
        issue(1, 3'd5, 32'hDEADBEEF, 32'h1234, 32'h0, 1'b0);
        repeat (16) @(posedge clk);
        #1 kill1 = 1'b1;
        @(posedge clk);
        #1 kill1 = 1'b0;
        chk("in_ready_after_kill", ir1, 1'b1);
        repeat (40) @(negedge clk);
        issue(1, 3'd5, 32'hDEADBEEF, 32'h1234,
              ref_model(3'd5, 32'hDEADBEEF, 32'h1234), 1'b1);
        drain();

        // Reset in the middle of an operation.
        issue(1, 3'd0, 32'h1234, 32'h5678, 32'h0, 1'b1);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        q1.delete();
        seen1 = 1'b0;
        #1;
        chk("midrun_rst_in_ready", ir1, 1'b1);
        chk("midrun_rst_out_valid", ov1, 1'b0);
        chk("midrun_rst_res", r1, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            s = 3'($urandom_range(0, 7));
            x = rnd_opnd();
            y = rnd_opnd();
            issue(1, s, x, y, ref_model(s, x, y), 1'b1);
            s = 3'($urandom_range(0, 7));
            x = rnd_opnd();
            y = rnd_opnd();
            issue(4, s, x, y, ref_model(s, x, y), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the combinational `alu`. It is the sequential counterpart to the ALU: operands arrive through a valid/ready request port, are processed over a fixed number of cycles, and the result is held on a valid/ready response port. It sits in the execute stage, which stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32: operand/result width; even, ≥ 8.
- `BITS_PER_CYCLE`, 1: quotient/multiplier bits retired per iteration; one of 1, 2, 4; must divide `XLEN`. Define N = `XLEN`/`BITS_PER_CYCLE`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `sel`  in  3  op, equal to RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op1`  in  XLEN  rs1 value.
- `op2`  in  XLEN  rs2 value.
- `kill`  in  1  synchronous abort of the in-flight operation.
- `out_valid`  out  1  `res` is valid.
- `out_ready`  in  1  consumer takes `res`.
- `res`  out  XLEN  result.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: `in_ready`=1. If `in_valid` && !`kill`: latch `sel`, `op1`, `op2` → PREP. Inputs are ignored outside the accept edge.
- PREP: compute operand magnitudes per signedness (MUL/MULH/DIV/REM: both signed; MULHSU: op1 signed, op2 unsigned; MULHU/DIVU/REMU: unsigned). Record result sign. Clear iteration counter.
  - Divide by zero (op2=0, sel 4–7): `res` = all-ones for DIV/DIVU, `op1` for REM/REMU → DONE.
  - Signed overflow (sel 4 or 6, op1 = −2^(XLEN−1), op2 = −1): DIV gives −2^(XLEN−1), REM gives 0 → DONE.
  - Otherwise → RUN.
- RUN: N iterations, one per cycle. Multiply: shift-add over a 2·XLEN accumulator, `BITS_PER_CYCLE` multiplier bits per cycle. Divide: restoring division producing `BITS_PER_CYCLE` quotient bits per cycle. After iteration N → FIX.
- FIX: apply the sign: two's-complement the product if the operand signs differ; the quotient if the dividend and divisor signs differ; the remainder if the dividend is negative. Select the result: MUL low XLEN, MULH* high XLEN, DIV* quotient, REM* remainder. → DONE.
- DONE: `out_valid`=1 and `res` stable until `out_valid && out_ready`, then → IDLE. No request is accepted in the handshake cycle.
- Arithmetic is modulo 2^XLEN. Overflow is ignored except for the defined special cases.
- `kill`: from any state, the next edge goes to IDLE, drops `out_valid`, and discards the result. In IDLE, `kill` blocks acceptance.
- `rst_n` low: immediately IDLE, `in_ready`=1, `out_valid`=0, `res`=0, all internal registers cleared, including in mid-operation.

## Timing
- Edge 0 is the accept edge (IDLE with `in_valid`=1).
- Normal ops: PREP→RUN at edge 1; iterations on edges 2..N+1; FIX→DONE at edge N+2. `out_valid` rises after edge N+2. XLEN=32, BPC=1: 34 cycles.
- Special cases (div-by-zero, overflow): `out_valid` rises after edge 1.
- `in_ready` is registered from state: 0 from after edge 0 until after the response-handshake edge.
- `res` is registered and changes only when entering DONE or on reset.
- Minimum request spacing: N+4 cycles with `out_ready` held at 1.
- No combinational path from `in_valid`/`out_ready` to any output.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32, BPC=1 → `res`=0xFFFFFFEB; `out_valid` first seen after edge 34; `in_ready` low throughout.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0x80000000×2 → 0.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU 0xFFFFFFF9/2 → 1. REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0. All four: `out_valid` after edge 1.
- Backpressure and kill:
  - `out_ready`=0 for 10 cycles in DONE → `res` and `out_valid` stable, `in_ready`=0; after the handshake, `in_ready`=1 next cycle.
  - `kill` pulse at iteration 16 → `out_valid` never rises; `in_ready`=1 after the kill edge; the next op is correct.
- `rst_n` asserted low mid-RUN → `out_valid`=0, `res`=0, `in_ready`=1 without a clock edge. Separately, a BPC=4 instance: DIV 100/7 → 14, `out_valid` after edge 10.
